// File: rtl/cam_periph_pkg.sv
// Shared definitions for the camera capture peripheral.
// Holds the J1 register offsets, the CTRL/STATUS bit positions
// and the capture FSM state encoding.
package cam_periph_pkg;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_RADDR    = 4'h2;
  localparam logic [3:0] REG_PIX_HI   = 4'h4;
  localparam logic [3:0] REG_PIX_LO   = 4'h6;
  localparam logic [3:0] REG_STATUS   = 4'h8;
  localparam logic [3:0] REG_COUNT_LO = 4'hA;
  localparam logic [3:0] REG_COUNT_HI = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_ARMED = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/cam_frame_ram.sv
// Frame buffer for the capture peripheral.
// Simple dual-port RAM: one write port, one synchronous read port
// with a single cycle of latency. A read and a write to the same
// address in one cycle return the old contents.
// Ports:
//   clk   - system clock
//   we    - write enable
//   waddr - write address
//   wdata - pixel to store
//   raddr - read address
//   rdata - registered read data
module cam_frame_ram #(
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 76800
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Read samples the array before this edge's write lands, giving old data on collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cam_capture_periph.sv
// J1 I/O-mapped camera capture peripheral.
// Captures one frame (or frames back to back in continuous mode)
// from a clk-synchronous camera stream into an internal frame RAM,
// and exposes control, status, an auto-incrementing read pointer,
// the live pixel count and a frame-done interrupt on the 16-bit bus.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   d_in, cs, addr   - J1 write data, chip select, register offset
//   rd, wr           - J1 read / write strobes
//   data_out         - registered read data (0 when not reading)
//   cam_vsync        - frame sync; rising edge ends, falling edge starts a frame
//   cam_href         - line valid
//   pixel_valid      - one-cycle pixel strobe
//   cam_pixel        - pixel data
//   busy             - FSM not idle
//   irq              - registered done && irq_en
module cam_capture_periph
  import cam_periph_pkg::*;
#(
  parameter int PIX_W        = 24,
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      d_in,
  input  logic             cs,
  input  logic [3:0]       addr,
  input  logic             rd,
  input  logic             wr,
  output logic [15:0]      data_out,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic             pixel_valid,
  input  logic [PIX_W-1:0] cam_pixel,
  output logic             busy,
  output logic             irq
);

  // wptr carries one extra bit so it can hold FRAME_PIXELS itself, the "full" mark.
  localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] RPTR_LAST = ADDR_W'(FRAME_PIXELS - 1);

  cap_state_t        state, state_nxt;
  logic              cont, irq_en, done, overflow, vsync_q;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   wptr;
  logic [PIX_W-1:0]  rdata;
  logic [31:0]       pix_ext, wptr_ext;
  logic [15:0]       rd_mux;

  logic bus_wr, bus_rd, ctrl_wr, start, abort;
  logic vs_rise, vs_fall, pix_in, frame_full, ram_we, pix_drop;

  assign bus_wr     = cs && wr;
  assign bus_rd     = cs && rd;
  assign ctrl_wr    = bus_wr && (addr == REG_CTRL);
  assign start      = ctrl_wr && d_in[CTRL_START];
  assign abort      = ctrl_wr && d_in[CTRL_ABORT];
  assign vs_rise    = cam_vsync && !vsync_q;
  assign vs_fall    = !cam_vsync && vsync_q;
  assign pix_in     = pixel_valid && cam_href;
  assign frame_full = (wptr == FRAME_END);
  assign ram_we     = (state == ST_CAPTURE) && pix_in && !frame_full && !abort;
  assign pix_drop   = (state == ST_CAPTURE) && pix_in && frame_full && !abort;
  assign busy       = (state != ST_IDLE);

  cam_frame_ram #(
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W),
    .DEPTH (FRAME_PIXELS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wptr[ADDR_W-1:0]),
    .wdata(cam_pixel),
    .raddr(rptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort overrides everything, including a start in the same write.
  // A start seen outside IDLE is simply ignored.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) state_nxt = ST_ARM;
        ST_ARM:     if (vs_fall) state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (vs_rise) state_nxt = ST_DONE;
        ST_DONE:    state_nxt = cont ? ST_ARM : ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status clears come before the sets so a set in the same cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cont     <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      vsync_q  <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      irq      <= 1'b0;
      data_out <= '0;
    end else begin
      vsync_q <= cam_vsync;
      irq     <= done && irq_en;
      data_out <= bus_rd ? rd_mux : 16'h0000;

      if (ctrl_wr) begin
        cont   <= d_in[CTRL_CONT];
        irq_en <= d_in[CTRL_IRQ_EN];
      end

      if (bus_wr && (addr == REG_STATUS)) begin
        if (d_in[STAT_DONE]) done <= 1'b0;
        if (d_in[STAT_OVF])  overflow <= 1'b0;
      end

      if (!abort) begin
        if (state == ST_IDLE && start) begin
          wptr     <= '0;
          overflow <= 1'b0;
        end else if (state == ST_DONE && cont) begin
          wptr <= '0;
        end else if (ram_we) begin
          wptr <= wptr + 1'b1;
        end
        if (state == ST_DONE) done <= 1'b1;
        if (pix_drop) overflow <= 1'b1;
      end

      if (bus_wr && (addr == REG_RADDR)) begin
        rptr <= ADDR_W'({16'h0000, d_in});
      end else if (bus_rd && (addr == REG_PIX_LO)) begin
        rptr <= (rptr == RPTR_LAST) ? '0 : rptr + 1'b1;
      end
    end
  end

  assign pix_ext  = 32'(rdata);
  assign wptr_ext = 32'(wptr);

  always_comb begin
    rd_mux = 16'h0000;
    case (addr)
      REG_CTRL: begin
        rd_mux[CTRL_CONT]   = cont;
        rd_mux[CTRL_IRQ_EN] = irq_en;
      end
      REG_RADDR:    rd_mux = 16'(rptr);
      REG_PIX_HI:   rd_mux = pix_ext[31:16];
      REG_PIX_LO:   rd_mux = pix_ext[15:0];
      REG_STATUS:   rd_mux = {12'h000, (state == ST_ARM), overflow, done, busy};
      REG_COUNT_LO: rd_mux = wptr_ext[15:0];
      REG_COUNT_HI: rd_mux = wptr_ext[31:16];
      default:      rd_mux = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_cam_capture_periph.sv
// Directed bench for cam_capture_periph.
// Two instances share the camera pins and bus signals but have
// separate chip selects: a 64-pixel one for the main scenarios and
// a 16-pixel one for overflow and read-pointer wrap.
module tb_cam_capture_periph;
  import cam_periph_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        cs_main, cs_ovf;
  logic [3:0]  addr;
  logic        rd, wr;
  logic        cam_vsync, cam_href, pixel_valid;
  logic [23:0] cam_pixel;
  logic [15:0] data_out_main, data_out_ovf;
  logic        busy_main, busy_ovf, irq_main, irq_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cam_capture_periph #(.PIX_W(24), .ADDR_W(6), .FRAME_PIXELS(64)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs_main), .addr(addr),
    .rd(rd), .wr(wr), .data_out(data_out_main),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .pixel_valid(pixel_valid),
    .cam_pixel(cam_pixel), .busy(busy_main), .irq(irq_main)
  );

  cam_capture_periph #(.PIX_W(24), .ADDR_W(4), .FRAME_PIXELS(16)) dut_ovf (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs_ovf), .addr(addr),
    .rd(rd), .wr(wr), .data_out(data_out_ovf),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .pixel_valid(pixel_valid),
    .cam_pixel(cam_pixel), .busy(busy_ovf), .irq(irq_ovf)
  );

  typedef struct {
    bit          is_wr;
    logic [3:0]  a;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input bit tgt, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cs_main = !tgt; cs_ovf = tgt; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs_main = 1'b0; cs_ovf = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input bit tgt, input logic [3:0] a, output logic [15:0] q);
    @(negedge clk);
    cs_main = !tgt; cs_ovf = tgt; rd = 1'b1; addr = a;
    @(negedge clk);
    q = tgt ? data_out_ovf : data_out_main;
    cs_main = 1'b0; cs_ovf = 1'b0; rd = 1'b0;
  endtask

  task automatic read_check(input bit tgt, input logic [3:0] a, input logic [15:0] exp, input string name);
    logic [15:0] q;
    idle(2);
    bus_read(tgt, a, q);
    check_output(name, q, exp);
  endtask

  task automatic apply_stimulus(input bit tgt, input vec_t v);
    idle(2);
    if (v.is_wr) bus_write(tgt, v.a, v.wdata);
    else read_check(tgt, v.a, v.exp, v.name);
  endtask

  // High for four cycles: long enough for DONE to return to ARM before the fall.
  task automatic vsync_pulse();
    @(negedge clk) cam_vsync = 1'b1;
    repeat (4) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_line(input int n, input logic [23:0] base);
    for (int p = 0; p < n; p++) begin
      @(negedge clk);
      cam_href = 1'b1; pixel_valid = 1'b1; cam_pixel = base + 24'(p);
    end
    @(negedge clk);
    cam_href = 1'b0; pixel_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, REG_COUNT_LO, 16'h0000, 16'd32,   "frame COUNT_LO"};
    vecs[1]  = '{1'b0, REG_COUNT_HI, 16'h0000, 16'h0000, "frame COUNT_HI"};
    vecs[2]  = '{1'b0, REG_STATUS,   16'h0000, 16'h0002, "frame STATUS"};
    vecs[3]  = '{1'b0, REG_CTRL,     16'h0000, 16'h0008, "CTRL readback"};
    vecs[4]  = '{1'b1, REG_RADDR,    16'h0000, 16'h0000, "RADDR=0"};
    vecs[5]  = '{1'b0, REG_PIX_HI,   16'h0000, 16'h00A5, "PIX_HI[0]"};
    vecs[6]  = '{1'b0, REG_PIX_LO,   16'h0000, 16'h0000, "PIX_LO[0]"};
    vecs[7]  = '{1'b0, REG_PIX_LO,   16'h0000, 16'h0001, "PIX_LO[1] autoinc"};
    vecs[8]  = '{1'b0, REG_PIX_LO,   16'h0000, 16'h0002, "PIX_LO[2] autoinc"};
    vecs[9]  = '{1'b1, REG_RADDR,    16'd31,   16'h0000, "RADDR=31"};
    vecs[10] = '{1'b0, REG_PIX_LO,   16'h0000, 16'h001F, "PIX_LO[31]"};
    vecs[11] = '{1'b0, REG_RADDR,    16'h0000, 16'h0020, "RADDR readback"};
    vecs[12] = '{1'b0, 4'hE,         16'h0000, 16'h0000, "offset 0xE"};
    vecs[13] = '{1'b1, REG_STATUS,   16'h0002, 16'h0000, "W1C done"};
    vecs[14] = '{1'b0, REG_STATUS,   16'h0000, 16'h0000, "STATUS after W1C"};

    rst = 1'b0; cs_main = 1'b0; cs_ovf = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = 4'h0; d_in = 16'h0000; cam_vsync = 1'b0; cam_href = 1'b0;
    pixel_valid = 1'b0; cam_pixel = '0;
    idle(2);
    check_output("reset data_out", data_out_main, 16'h0000);
    check_output("reset busy", {15'h0, busy_main}, 16'h0000);
    check_output("reset irq", {15'h0, irq_main}, 16'h0000);
    rst = 1'b1;
    idle(2);

    $display("[TB] single frame");
    bus_write(1'b0, REG_CTRL, 16'h0009);
    vsync_pulse();
    for (int l = 0; l < 4; l++) begin
      send_line(8, 24'hA50000 + 24'(l * 8));
      idle(2);
    end
    vsync_pulse();
    check_output("frame irq", {15'h0, irq_main}, 16'h0001);
    for (int i = 0; i < 15; i++) apply_stimulus(1'b0, vecs[i]);
    idle(2);
    check_output("irq after W1C", {15'h0, irq_main}, 16'h0000);

    $display("[TB] mid-frame start / start while busy / W1C in DONE");
    bus_write(1'b0, REG_CTRL, 16'h0001);
    send_line(8, 24'h000300);
    read_check(1'b0, REG_COUNT_LO, 16'h0000, "armed COUNT_LO");
    read_check(1'b0, REG_STATUS, 16'h0009, "armed STATUS");
    vsync_pulse();
    send_line(5, 24'h000400);
    read_check(1'b0, REG_COUNT_LO, 16'd5, "capture COUNT_LO");
    bus_write(1'b0, REG_CTRL, 16'h0001);
    read_check(1'b0, REG_COUNT_LO, 16'd5, "start while busy COUNT_LO");
    read_check(1'b0, REG_STATUS, 16'h0001, "capture STATUS");
    @(negedge clk) cam_vsync = 1'b1;
    @(negedge clk);
    cs_main = 1'b1; wr = 1'b1; addr = REG_STATUS; d_in = 16'h0002;
    @(negedge clk);
    cs_main = 1'b0; wr = 1'b0;
    idle(2);
    cam_vsync = 1'b0;
    idle(2);
    read_check(1'b0, REG_STATUS, 16'h0002, "W1C in DONE cycle");
    bus_write(1'b0, REG_RADDR, 16'h0000);
    read_check(1'b0, REG_PIX_LO, 16'h0400, "first pixel after vs_fall");

    $display("[TB] continuous + abort");
    bus_write(1'b0, REG_STATUS, 16'h0002);
    bus_write(1'b0, REG_CTRL, 16'h0003);
    vsync_pulse();
    send_line(6, 24'h000500);
    read_check(1'b0, REG_COUNT_LO, 16'd6, "cont frame1 COUNT_LO");
    vsync_pulse();
    read_check(1'b0, REG_COUNT_LO, 16'h0000, "cont restart COUNT_LO");
    read_check(1'b0, REG_STATUS, 16'h0003, "cont done#1 STATUS");
    bus_write(1'b0, REG_STATUS, 16'h0002);
    read_check(1'b0, REG_STATUS, 16'h0001, "cont cleared STATUS");
    send_line(3, 24'h000600);
    read_check(1'b0, REG_COUNT_LO, 16'd3, "cont frame2 COUNT_LO");
    vsync_pulse();
    read_check(1'b0, REG_COUNT_LO, 16'h0000, "cont restart2 COUNT_LO");
    read_check(1'b0, REG_STATUS, 16'h0003, "cont done#2 STATUS");
    check_output("cont busy", {15'h0, busy_main}, 16'h0001);
    bus_write(1'b0, REG_CTRL, 16'h0005);
    check_output("abort busy", {15'h0, busy_main}, 16'h0000);
    read_check(1'b0, REG_STATUS, 16'h0002, "abort STATUS");

    $display("[TB] overflow + wrap");
    bus_write(1'b1, REG_CTRL, 16'h0001);
    vsync_pulse();
    send_line(20, 24'h000100);
    vsync_pulse();
    read_check(1'b1, REG_COUNT_LO, 16'd16, "ovf COUNT_LO");
    read_check(1'b1, REG_STATUS, 16'h0006, "ovf STATUS");
    bus_write(1'b1, REG_STATUS, 16'h0004);
    read_check(1'b1, REG_STATUS, 16'h0002, "ovf W1C STATUS");
    bus_write(1'b1, REG_RADDR, 16'd15);
    read_check(1'b1, REG_PIX_LO, 16'h010F, "ovf PIX_LO[15]");
    read_check(1'b1, REG_PIX_LO, 16'h0100, "wrap PIX_LO[0]");
    read_check(1'b1, REG_RADDR, 16'h0001, "wrap RADDR");

    $display("[TB] reset mid-capture");
    bus_write(1'b0, REG_CTRL, 16'h0009);
    vsync_pulse();
    send_line(4, 24'h000700);
    check_output("pre-reset busy", {15'h0, busy_main}, 16'h0001);
    check_output("pre-reset irq", {15'h0, irq_main}, 16'h0001);
    @(negedge clk);
    cs_main = 1'b1; rd = 1'b1; addr = REG_COUNT_LO;
    @(negedge clk);
    check_output("pre-reset data_out", data_out_main, 16'd4);
    rst = 1'b0;
    #1;
    check_output("mid reset data_out", data_out_main, 16'h0000);
    check_output("mid reset busy", {15'h0, busy_main}, 16'h0000);
    check_output("mid reset irq", {15'h0, irq_main}, 16'h0000);
    cs_main = 1'b0; rd = 1'b0;
    @(negedge clk) rst = 1'b1;
    read_check(1'b0, REG_STATUS, 16'h0000, "post-reset STATUS");
    read_check(1'b0, REG_COUNT_LO, 16'h0000, "post-reset COUNT_LO");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
